// File: rtl/uop_tribus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus.
// grant is a registered one-hot drive enable, and a turnaround gap separates tenures.
module uop_tribus_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAXHOLD  = 8,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timed_out
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned HW = $clog2(MAXHOLD + 1);
  localparam int unsigned TW = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   turn_q, turn_d;
  logic [IW-1:0]   last_q, last_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic            busy_q, busy_d;
  logic            timed_out_q, timed_out_d;
  logic            forced_rel;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  // Round-robin search starting one past the last owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(last_q) + 32'd1 + i) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      turn_q      <= '0;
      last_q      <= IW'(N - 1);
      grant_q     <= '0;
      gnt_id_q    <= '0;
      busy_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      turn_q      <= turn_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      gnt_id_q    <= gnt_id_d;
      busy_q      <= busy_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Next state; a release by the owner takes precedence over the hold limit.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    last_d     = last_q;
    forced_rel = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          hold_d  = HW'(1);
          last_d  = win_idx;
        end
      end
      GRANT: begin
        if (!req[last_q]) begin
          state_d = TURN;
          hold_d  = '0;
          turn_d  = TW'(1);
        end else if (hold_q == HW'(MAXHOLD)) begin
          state_d    = TURN;
          hold_d     = '0;
          turn_d     = TW'(1);
          forced_rel = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_q == TW'(TURN_CYC)) begin
          turn_d = '0;
          if (win_found) begin
            state_d = GRANT;
            hold_d  = HW'(1);
            last_d  = win_idx;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, registered alongside the state.
  always_comb begin
    grant_d     = '0;
    busy_d      = 1'b0;
    gnt_id_d    = gnt_id_q;
    timed_out_d = forced_rel;
    if (state_d == GRANT) begin
      grant_d  = N'(1) << last_d;
      busy_d   = 1'b1;
      gnt_id_d = last_d;
    end
  end

  assign grant     = grant_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = busy_q;
  assign timed_out = timed_out_q;

endmodule
